// File: rtl/ps2_rx_if.sv
// Received-byte stream from ps2_rx towards its consumer (ps2_mouse).
interface ps2_rx_if;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       frame_err;
  logic       busy;

  modport master (output byte_out, output byte_valid, output frame_err, output busy);
  modport slave  (input  byte_out, input  byte_valid, input  frame_err, input  busy);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and glitch-filters the raw lines,
// then deserializes start/8 data/odd parity/stop frames with a stall watchdog.
module ps2_rx #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 20000
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     MOUSE_CLOCK,
  input  logic     MOUSE_DATA,
  input  logic     inhibit,
  ps2_rx_if.master rx
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Bit 0 carries the clock line, bit 1 the data line.
  logic [1:0]    raw;
  logic [1:0]    sync1_q, sync2_q, filt_q;
  logic [FW-1:0] fcnt_q [2];
  logic          clk_prev_q;
  logic          fall;
  logic          dat;

  assign raw  = {MOUSE_DATA, MOUSE_CLOCK};
  assign fall = clk_prev_q & ~filt_q[0];
  assign dat  = filt_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      filt_q     <= '1;
      fcnt_q[0]  <= '0;
      fcnt_q[1]  <= '0;
      clk_prev_q <= 1'b1;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      clk_prev_q <= filt_q[0];
      // Filtered line follows only after FILTER_LEN consecutive disagreeing samples.
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  state_t        state_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [WW-1:0] wdog_q;
  logic [7:0]    byte_q;
  logic          valid_q;
  logic          err_q;
  logic          busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      wdog_q   <= '0;
      byte_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (inhibit) begin
        state_q  <= IDLE;
        busy_q   <= 1'b0;
        wdog_q   <= '0;
        bitcnt_q <= '0;
      end else if (fall) begin
        wdog_q <= '0;
        case (state_q)
          IDLE: begin
            if (!dat) begin
              state_q  <= DATA;
              bitcnt_q <= '0;
              busy_q   <= 1'b1;
            end
          end
          DATA: begin
            shift_q  <= {dat, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= dat;
            state_q <= STOP;
          end
          STOP: begin
            if ((^shift_q ^ par_q) && dat) begin
              byte_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q != IDLE) begin
        if (wdog_q == WW'(TIMEOUT - 1)) begin
          err_q   <= 1'b1;
          state_q <= IDLE;
          busy_q  <= 1'b0;
          wdog_q  <= '0;
        end else begin
          wdog_q <= wdog_q + 1'b1;
        end
      end
    end
  end

  assign rx.byte_out   = byte_q;
  assign rx.byte_valid = valid_q;
  assign rx.frame_err  = err_q;
  assign rx.busy       = busy_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: good/bad frames, timeout, glitches, inhibit and reset.
module tb_ps2_rx;
  localparam int FL = 8;
  localparam int TO = 300;
  localparam int H  = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic MOUSE_CLOCK = 1'b1;
  logic MOUSE_DATA  = 1'b1;
  logic inhibit = 1'b0;

  ps2_rx_if rx_if ();

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .MOUSE_CLOCK(MOUSE_CLOCK), .MOUSE_DATA(MOUSE_DATA),
    .inhibit(inhibit), .rx(rx_if)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0, nvec = 0, nmis = 0;
  int unsigned nvalid = 0, nerr = 0, nboth = 0, t_fall = 0, t_strobe = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_if.byte_valid) begin nvalid++; t_strobe = cyc; end
    if (rx_if.frame_err)  begin nerr++;   t_strobe = cyc; end
    if (rx_if.byte_valid && rx_if.frame_err) nboth++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  task automatic clk_bit(input logic b, input bit glitch);
    MOUSE_DATA = b;
    if (glitch) begin
      wait_cyc(6);
      MOUSE_DATA = ~b;
      wait_cyc(3);
      MOUSE_DATA = b;
      wait_cyc(H/2 - 9);
    end else begin
      wait_cyc(H/2);
    end
    MOUSE_CLOCK = 1'b0;
    t_fall = cyc;
    wait_cyc(H);
    MOUSE_CLOCK = 1'b1;
    wait_cyc(H/2);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int lo, input int hi, input int gidx);
    for (int i = lo; i <= hi; i++) clk_bit(bits[i], i == gidx);
    MOUSE_DATA = 1'b1;
  endtask

  task automatic good_frame(input string tag, input logic [7:0] d, input logic p, input int gidx);
    int unsigned v0, e0;
    v0 = nvalid; e0 = nerr;
    send_bits(frame(d, p, 1'b1), 0, 10, gidx);
    wait_cyc(20);
    check_eq({tag, "_valid"}, nvalid - v0, 1);
    check_eq({tag, "_err"},   nerr - e0, 0);
    check_eq({tag, "_byte"},  rx_if.byte_out, d);
    check_eq({tag, "_lat"},   t_strobe - t_fall, FL + 3);
    check_eq({tag, "_busy"},  rx_if.busy, 0);
  endtask

  task automatic bad_frame(input string tag, input logic [7:0] d, input logic p, input logic s,
                           input logic [7:0] keep);
    int unsigned v0, e0;
    v0 = nvalid; e0 = nerr;
    send_bits(frame(d, p, s), 0, 10, -1);
    wait_cyc(20);
    check_eq({tag, "_valid"}, nvalid - v0, 0);
    check_eq({tag, "_err"},   nerr - e0, 1);
    check_eq({tag, "_byte"},  rx_if.byte_out, keep);
    check_eq({tag, "_lat"},   t_strobe - t_fall, FL + 3);
    check_eq({tag, "_busy"},  rx_if.busy, 0);
  endtask

  initial begin
    int unsigned v0, e0;
    bit seen;

    wait_cyc(3);
    check_eq("rst_byte",  rx_if.byte_out, 8'h00);
    check_eq("rst_valid", rx_if.byte_valid, 0);
    check_eq("rst_err",   rx_if.frame_err, 0);
    check_eq("rst_busy",  rx_if.busy, 0);
    rst = 1'b1;
    wait_cyc(10);

    good_frame("fa", 8'hFA, 1'b1, -1);
    wait_cyc(50);
    good_frame("b08", 8'h08, 1'b0, -1);
    good_frame("b00", 8'h00, 1'b1, -1);

    bad_frame("par", 8'hFA, 1'b0, 1'b1, 8'h00);
    wait_cyc(50);
    bad_frame("stop", 8'hFA, 1'b1, 1'b0, 8'h00);
    wait_cyc(50);

    // Start plus four data bits, then the clock stays high.
    v0 = nvalid; e0 = nerr; seen = 1'b0;
    send_bits(frame(8'h00, 1'b1, 1'b1), 0, 4, -1);
    for (int i = 0; i < 2*TO && !seen; i++) begin
      @(negedge clk);
      if (nerr != e0) seen = 1'b1;
    end
    check_eq("to_seen",  nerr - e0, 1);
    check_eq("to_lat",   t_strobe - t_fall, FL + 3 + TO);
    check_eq("to_busy",  rx_if.busy, 0);
    check_eq("to_valid", nvalid - v0, 0);
    wait_cyc(50);
    good_frame("to_next", 8'h00, 1'b1, -1);

    v0 = nvalid; e0 = nerr;
    MOUSE_CLOCK = 1'b0;
    wait_cyc(3);
    MOUSE_CLOCK = 1'b1;
    wait_cyc(30);
    check_eq("cglitch_busy", rx_if.busy, 0);
    check_eq("cglitch_strb", (nvalid - v0) + (nerr - e0), 0);
    good_frame("dglitch", 8'hFA, 1'b1, 4);

    // Inhibit after start and three data bits; the rest of the frame arrives while inhibited.
    wait_cyc(50);
    v0 = nvalid; e0 = nerr;
    send_bits(frame(8'h55, 1'b1, 1'b1), 0, 3, -1);
    check_eq("inh_busy_pre", rx_if.busy, 1);
    inhibit = 1'b1;
    wait_cyc(3);
    check_eq("inh_busy", rx_if.busy, 0);
    send_bits(frame(8'h55, 1'b1, 1'b1), 4, 10, -1);
    inhibit = 1'b0;
    wait_cyc(30);
    check_eq("inh_strb", (nvalid - v0) + (nerr - e0), 0);
    check_eq("inh_busy_post", rx_if.busy, 0);
    check_eq("inh_byte", rx_if.byte_out, 8'hFA);

    v0 = nvalid; e0 = nerr;
    send_bits(frame(8'hAA, 1'b1, 1'b1), 0, 5, -1);
    check_eq("rmid_busy_pre", rx_if.busy, 1);
    rst = 1'b0;
    #1;
    check_eq("rmid_byte", rx_if.byte_out, 8'h00);
    check_eq("rmid_busy", rx_if.busy, 0);
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(30);
    check_eq("rmid_strb", (nvalid - v0) + (nerr - e0), 0);
    check_eq("rmid_busy_post", rx_if.busy, 0);
    good_frame("aa", 8'hAA, 1'b1, -1);

    check_eq("excl", nboth, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
